// File: rtl/universal_shiftreg.sv
// Universal shift register: shl/shr/rotl/rotr over a programmed step count, parallel load, start/done handshake.
// Define SHIFTREG_PARITY_EN to add the combinational parity output (^q).
module universal_shiftreg #(
  parameter int WIDTH = 6,
  parameter int AMT_W = 3
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [AMT_W-1:0] amount,
  input  logic             sin,
  input  logic [WIDTH-1:0] pdata,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             busy,
  output logic             done
`ifdef SHIFTREG_PARITY_EN
  ,
  output logic             parity
`endif
);

  // state  | meaning
  // S_IDLE | waiting for start; q holds
  // S_RUN  | one step of the latched mode per edge, count counts down
  // S_DONE | one-cycle done pulse; start ignored
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [2:0] M_HOLD = 3'd0;
  localparam logic [2:0] M_SHL  = 3'd1;
  localparam logic [2:0] M_SHR  = 3'd2;
  localparam logic [2:0] M_ROTL = 3'd3;
  localparam logic [2:0] M_ROTR = 3'd4;
  localparam logic [2:0] M_LOAD = 3'd5;

  state_t           state;
  state_t           state_nxt;
  logic [2:0]       mode_l;
  logic [AMT_W-1:0] count;
  logic [WIDTH-1:0] q_step;
  logic             is_shift;

  assign is_shift = (mode >= M_SHL) && (mode <= M_ROTR);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (is_shift && (amount != '0)) state_nxt = S_RUN;
          else                            state_nxt = S_DONE;
        end
      end
      S_RUN:   if (count == AMT_W'(1)) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == S_RUN);
    done = (state == S_DONE);
    // Right-moving modes expose the bit about to fall off the low end.
    if ((mode_l == M_SHR) || (mode_l == M_ROTR)) sout = q[0];
    else                                         sout = q[WIDTH-1];
  end

  always_comb begin
    q_step = q;
    case (mode_l)
      M_SHL:   q_step = {q[WIDTH-2:0], sin};
      M_SHR:   q_step = {sin, q[WIDTH-1:1]};
      M_ROTL:  q_step = {q[WIDTH-2:0], q[WIDTH-1]};
      M_ROTR:  q_step = {q[0], q[WIDTH-1:1]};
      default: q_step = q;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      q      <= '0;
      count  <= '0;
      mode_l <= M_HOLD;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            mode_l <= mode;
            count  <= amount;
            if (mode == M_LOAD) q <= pdata;
          end
        end
        S_RUN: begin
          q     <= q_step;
          count <= count - AMT_W'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef SHIFTREG_PARITY_EN
  assign parity = ^q;
`endif

endmodule

// File: tb/tb_universal_shiftreg.sv
// Self-checking bench for universal_shiftreg (WIDTH=6, AMT_W=3): directed cases plus random traffic
// compared every cycle against an arithmetic reference model.
module tb_universal_shiftreg;

  logic       clock;
  logic       resetn;
  logic       start;
  logic [2:0] mode;
  logic [2:0] amount;
  logic       sin;
  logic [5:0] pdata;
  logic [5:0] q;
  logic       sout;
  logic       busy;
  logic       done;
`ifdef SHIFTREG_PARITY_EN
  logic       parity;
`endif

  universal_shiftreg #(.WIDTH(6), .AMT_W(3)) dut (
    .clock  (clock),
    .resetn (resetn),
    .start  (start),
    .mode   (mode),
    .amount (amount),
    .sin    (sin),
    .pdata  (pdata),
    .q      (q),
    .sout   (sout),
    .busy   (busy),
    .done   (done)
`ifdef SHIFTREG_PARITY_EN
    ,
    .parity (parity)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: register value, last accepted mode, steps still owed, done-cycle flag.
  typedef struct {
    int q;
    int mode;
    int left;
    bit done;
  } mdl_t;

  mdl_t m;

  function automatic mdl_t model_next(mdl_t s, int st, int md, int amt, int si, int pd);
    mdl_t n;
    int   v;
    n = s;
    v = s.q;
    if (s.left > 0) begin
      case (s.mode)
        1: v = ((v * 2) + si) % 64;
        2: v = (v / 2) + si * 32;
        3: v = ((v * 2) % 64) + (v / 32);
        4: v = (v / 2) + (v % 2) * 32;
        default: ;
      endcase
      n.q    = v;
      n.left = s.left - 1;
      n.done = (s.left == 1);
    end else if (s.done) begin
      n.done = 1'b0;
    end else if (st != 0) begin
      n.mode = md;
      if (md == 5) begin
        n.q    = pd;
        n.done = 1'b1;
      end else if (md >= 1 && md <= 4 && amt != 0) begin
        n.left = amt;
      end else begin
        n.done = 1'b1;
      end
    end
    return n;
  endfunction

  always @(posedge clock or negedge resetn) begin
    if (!resetn) m <= '{q: 0, mode: 0, left: 0, done: 1'b0};
    else         m <= model_next(m, int'(start), int'(mode), int'(amount), int'(sin), int'(pdata));
  end

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    forever begin
      @(negedge clock);
      if (resetn) begin
        check("q", int'(q), m.q);
        check("busy", int'(busy), int'(m.left > 0));
        check("done", int'(done), int'(m.done));
        check("sout", int'(sout), (m.mode == 2 || m.mode == 4) ? (m.q % 2) : (m.q / 32));
`ifdef SHIFTREG_PARITY_EN
        check("parity", int'(parity), $countones(m.q) % 2);
`endif
      end
    end
  end

  task automatic issue(input logic [2:0] md, input logic [2:0] amt, input logic [5:0] pd);
    start  = 1'b1;
    mode   = md;
    amount = amt;
    pdata  = pd;
    @(negedge clock);
    start  = 1'b0;
  endtask

  initial begin
    int dones;
    resetn = 1'b0;
    start  = 1'b0;
    mode   = 3'd0;
    amount = 3'd0;
    sin    = 1'b0;
    pdata  = 6'd0;
    repeat (3) @(negedge clock);
    resetn = 1'b1;
    check("reset_q", int'(q), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_sout", int'(sout), 0);

    // Load 101101
    issue(3'd5, 3'd0, 6'b101101);
    check("load_q", int'(q), 45);
    check("load_done", int'(done), 1);
`ifdef SHIFTREG_PARITY_EN
    check("load_parity0", int'(parity), 0);
`endif
    @(negedge clock);
    check("load_done_low", int'(done), 0);

    // shl by 3 with sin=1: 101101 -> 101111
    sin = 1'b1;
    issue(3'd1, 3'd3, 6'd0);
    for (int i = 0; i < 3; i++) begin
      check("shl_busy", int'(busy), 1);
      @(negedge clock);
    end
    check("shl_q", int'(q), 47);
    check("shl_done", int'(done), 1);
    check("shl_busy_end", int'(busy), 0);
    @(negedge clock);

    // rotr by 7 from 100001: seven single-bit right rotations give 110000
    issue(3'd5, 3'd0, 6'b100001);
    @(negedge clock);
    issue(3'd4, 3'd7, 6'd0);
    repeat (7) @(negedge clock);
    check("rotr_q", int'(q), 48);
    check("rotr_done", int'(done), 1);
    check("rotr_sout", int'(sout), 0);
    @(negedge clock);

    // amount=0 shl: done next cycle, q unchanged
    issue(3'd1, 3'd0, 6'd0);
    check("amt0_done", int'(done), 1);
    check("amt0_q", int'(q), 48);
    @(negedge clock);
    check("amt0_done_low", int'(done), 0);

    // start pulsed during RUN is ignored
    dones = 0;
    issue(3'd1, 3'd5, 6'd0);
    for (int i = 0; i < 10; i++) begin
      dones += int'(done);
      if (i == 1) begin start = 1'b1; mode = 3'd5; pdata = 6'd0; end
      if (i == 2) start = 1'b0;
      @(negedge clock);
    end
    check("run_start_single_done", dones, 1);

    // Parity after load 000111
    issue(3'd5, 3'd0, 6'b000111);
    check("load7_q", int'(q), 7);
`ifdef SHIFTREG_PARITY_EN
    check("load_parity1", int'(parity), 1);
`endif
    @(negedge clock);

    // Async reset mid-RUN
    issue(3'd3, 3'd7, 6'd0);
    repeat (2) @(negedge clock);
    #2 resetn = 1'b0;
    #1;
    check("midrst_q", int'(q), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    @(negedge clock);
    resetn = 1'b1;
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      dones += int'(done);
      @(negedge clock);
    end
    check("midrst_no_done", dones, 0);

    // Random traffic, model-checked every cycle
    for (int i = 0; i < 600; i++) begin
      start  = ($urandom_range(0, 2) == 0);
      mode   = 3'($urandom_range(0, 7));
      amount = 3'($urandom_range(0, 7));
      sin    = 1'($urandom_range(0, 1));
      pdata  = 6'($urandom_range(0, 63));
      @(negedge clock);
    end
    start = 1'b0;
    repeat (12) @(negedge clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
